lightgun_multi: RTL
===================

# lightgun_multi

Parametrised multi-channel light-gun emulator for the NES core. Converts per-channel PS/2 mouse packets or absolute analog positions into a Zapper-style photodiode signal (`light`, active-low) and trigger signal. It compares each gun's aim point against the live PPU beam position and colour. It sits beside the controller port mux and drives one Zapper input per channel, plus reticle overlay flags for the video mixer.

## Interface
Parameters:
- NUM_GUNS, 2, number of independent gun channels (1..4)
- HIT_RADIUS, 4, half-width in pixels/lines of the light-sensing square
- TRIG_PULSE, 830000, clocks the trigger output stays high per shot
- TRIG_LOCKOUT, 2100000, clocks after the pulse during which new presses are dropped
- LIGHT_HI / LIGHT_MID / LIGHT_LO, 26 / 20 / 17, scanlines of light persistence per brightness class

Ports (per-channel buses are packed, channel 0 in the LSBs):
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- ps2_mouse  in  25*NUM_GUNS  {toggle, dy[7:0], dx[7:0], status[7:0]}; status bit4 = X sign, bit5 = Y sign, bit0 = left button
- abs_x, abs_y  in  8*NUM_GUNS each  unsigned absolute aim, 128 = centre
- ext_btn  in  NUM_GUNS  level trigger from a mapped joypad button
- src_sel  in  NUM_GUNS  0 = mouse positioning, 1 = absolute positioning
- trig_sel  in  NUM_GUNS  0 = mouse left button, 1 = ext_btn
- sens  in  2*NUM_GUNS  mouse delta arithmetic right-shift, 0..3
- cycle, scanline  in  9 each  current PPU dot and line
- color  in  6  NES palette index of the current dot
- light  out  NUM_GUNS  active-low photodiode (0 = light seen)
- trigger  out  NUM_GUNS  active-high trigger
- reticle  out  2*NUM_GUNS  per channel {offscreen, crosshair_dot}

## Operation
- Per channel: pos_x and pos_y, each 10-bit signed and held in 0..255; light_cnt (9 bit); trig_cnt (32 bit); pressed; old_toggle.
- New mouse packet: ps2_mouse bit24 differs from old_toggle. Both edges count.
- Mouse mode, on a new packet:
  - dx = {sign, byte} >>> sens; dy likewise.
  - pos_x += dx and pos_y -= dy, each computed in 11-bit signed and clamped to 0..255.
- Absolute mode, every cycle: pos_x = abs_x; pos_y = abs_y - (abs_y >> 4), so 255 maps to 240.
- Trigger source event:
  - Mouse source: new packet with the left button set.
  - Ext source: ext_btn high.
- When a source event occurs and pressed = 0:
  - Set pressed.
  - If trig_cnt == 0, load TRIG_PULSE + TRIG_LOCKOUT; otherwise drop the shot.
- pressed clears on a release: a new packet with the button clear, or ext_btn low.
- trig_cnt decrements to 0. trigger = trig_cnt > TRIG_LOCKOUT.
- offscreen = pos_x >= 254 or pos_x <= 1 or pos_y >= 224 or pos_y <= 8.
- in_square = |cycle - pos_x| <= HIT_RADIUS and |scanline - pos_y| <= HIT_RADIUS. Evaluate in 11-bit signed with no wrap.
- Light classes (apply only when in_square and not offscreen):
  - color 0x20 or 0x30: light_cnt = LIGHT_HI.
  - 0x31..0x3D or 0x10: light_cnt = max(light_cnt, LIGHT_MID).
  - 0x21..0x2D or 0x00: light_cnt = max(light_cnt, LIGHT_LO).
  - 0x0E/0x0F/0x1x others/0x2E/0x2F/0x3E/0x3F: no effect.
- Decay: light_cnt decrements by 1 when scanline differs from its registered copy and light_cnt > 0.
- light = (light_cnt == 0).
- reticle:
  - crosshair_dot = (scanline == pos_y and |cycle - pos_x| <= 1) or (cycle == pos_x and |scanline - pos_y| <= 1).
  - offscreen = offscreen.
- Simultaneous events:
  - A light load and a scanline decrement in the same cycle: the load wins.
  - A press while trig_cnt != 0 is lost; it does not queue.
  - Toggling src_sel mid-frame: pos holds its last value until the new source updates it.

## Timing
- Reset (async) values: pos = (128,120); light_cnt = 0; trig_cnt = 0; pressed = 0; old_toggle = 0; light = all 1; trigger = 0; reticle = 0.
- Packet or ext_btn edge to pos/trigger change: 1 clk.
- Beam dot to light low: 1 clk after the qualifying color/cycle/scanline sample.
- reticle is registered and lags the beam by 1 clk.
- trigger stays high exactly TRIG_PULSE clks. The next shot is accepted no earlier than TRIG_PULSE + TRIG_LOCKOUT clks after the load.
- Reset asserted mid-pulse: trigger drops asynchronously; no shot is pending after release.

## Test plan
- Reset, then mouse packet dx=+10, dy=+5, sens=0 on ch0 -> pos = (138,115) 1 clk later; ch1 unchanged at (128,120).
- Clamp: pos_x = 250, dx=+127, sens=2 -> dx=+31 -> pos_x = 255, reticle[1] = 1, and 0x30 pixels at (255,y) give no light.
- Light: pos = (100,100); color 0x30 at cycle 103, scanline 97 -> light[0] low next clk.
  - Light stays low through 25 further scanline changes and goes high on the 26th.
  - A 0x21 hit then keeps the current count if it is above 17.
- Trigger (TRIG_PULSE=8, TRIG_LOCKOUT=16 in bench): ext_btn rises -> trigger high for 8 clks.
  - A second press at clk 12 is dropped.
  - A press after release at clk 25 fires.
  - Holding ext_btn does not refire.
- Absolute mode: abs_y = 255 -> pos_y = 240; abs_y = 16 -> 15; abs_x = 0 -> reticle offscreen = 1.
- Mid-pulse async reset -> trigger = 0 and light = 1 immediately, with no clock edge needed.

Source files
------------

// File: rtl/lightgun_multi_if.sv
// lightgun_multi_if: aim, beam and Zapper signals for all gun channels.
// Channel 0 occupies the LSBs of every packed per-channel bus.
interface lightgun_multi_if #(
  parameter int NUM_GUNS = 2
);
  logic [25*NUM_GUNS-1:0] ps2_mouse;
  logic [8*NUM_GUNS-1:0]  abs_x;
  logic [8*NUM_GUNS-1:0]  abs_y;
  logic [NUM_GUNS-1:0]    ext_btn;
  logic [NUM_GUNS-1:0]    src_sel;
  logic [NUM_GUNS-1:0]    trig_sel;
  logic [2*NUM_GUNS-1:0]  sens;
  logic [8:0]             cycle;
  logic [8:0]             scanline;
  logic [5:0]             color;
  logic [NUM_GUNS-1:0]    light;
  logic [NUM_GUNS-1:0]    trigger;
  logic [2*NUM_GUNS-1:0]  reticle;

  modport master (
    output ps2_mouse, abs_x, abs_y, ext_btn,
    output src_sel, trig_sel, sens,
    output cycle, scanline, color,
    input  light, trigger, reticle
  );

  modport slave (
    input  ps2_mouse, abs_x, abs_y, ext_btn,
    input  src_sel, trig_sel, sens,
    input  cycle, scanline, color,
    output light, trigger, reticle
  );
endinterface

// File: rtl/lightgun_multi.sv
// lightgun_multi: multi-channel Zapper emulator for the NES core.
// Aim from mouse deltas or absolute input, compared to the PPU beam.
module lightgun_multi #(
  parameter int NUM_GUNS     = 2,
  parameter int HIT_RADIUS   = 4,
  parameter int TRIG_PULSE   = 830000,
  parameter int TRIG_LOCKOUT = 2100000,
  parameter int LIGHT_HI     = 26,
  parameter int LIGHT_MID    = 20,
  parameter int LIGHT_LO     = 17
) (
  input logic             clk,
  input logic             reset,
  lightgun_multi_if.slave bus
);
  localparam logic [31:0] TRIG_LOAD =
    32'(TRIG_PULSE + TRIG_LOCKOUT);
  localparam logic [31:0] TRIG_HOLD = 32'(TRIG_LOCKOUT);
  localparam logic [10:0] RADIUS    = 11'(HIT_RADIUS);
  localparam logic [8:0]  CNT_HI    = 9'(LIGHT_HI);
  localparam logic [8:0]  CNT_MID   = 9'(LIGHT_MID);
  localparam logic [8:0]  CNT_LO    = 9'(LIGHT_LO);

  logic signed [9:0] pos_x     [NUM_GUNS];
  logic signed [9:0] pos_y     [NUM_GUNS];
  logic [8:0]        light_cnt [NUM_GUNS];
  logic [31:0]       trig_cnt  [NUM_GUNS];
  logic [NUM_GUNS-1:0] pressed;
  logic [NUM_GUNS-1:0] old_toggle;
  logic [8:0]          scan_q;
  logic [2*NUM_GUNS-1:0] reticle_q;

  logic signed [9:0] nx_x     [NUM_GUNS];
  logic signed [9:0] nx_y     [NUM_GUNS];
  logic [8:0]        nx_light [NUM_GUNS];
  logic [31:0]       nx_trig  [NUM_GUNS];
  logic [NUM_GUNS-1:0]   nx_pressed;
  logic [2*NUM_GUNS-1:0] nx_ret;
  logic [5*NUM_GUNS-1:0] spare_unused;

  function automatic logic [10:0] mag(input logic [10:0] v);
    return v[10] ? -v : v;
  endfunction

  function automatic logic signed [9:0] clamp(
    input logic signed [10:0] v
  );
    if (v < 0) return '0;
    if (v > 11'sd255) return 10'sd255;
    return v[9:0];
  endfunction

  // 3 = bright, 2 = mid, 1 = dim, 0 = no light
  function automatic logic [1:0] lclass(input logic [5:0] c);
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      (c == 6'h20) || (c == 6'h30): r = 2'd3;
      ((c >= 6'h31) && (c <= 6'h3D)) || (c == 6'h10): r = 2'd2;
      ((c >= 6'h21) && (c <= 6'h2D)) || (c == 6'h00): r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    logic              fresh, btn, off, hit, dot, ev, rel;
    logic [1:0]        sh;
    logic signed [8:0] dx, dy;
    logic signed [10:0] sx, sy;
    logic [10:0]       ex, ey;
    logic [7:0]        ay;
    nx_ret       = '0;
    nx_pressed   = pressed;
    spare_unused = '0;
    for (int i = 0; i < NUM_GUNS; i++) begin
      fresh = bus.ps2_mouse[25*i+24] != old_toggle[i];
      btn   = bus.ps2_mouse[25*i];
      spare_unused[5*i +: 5] = {bus.ps2_mouse[25*i+7 -: 2],
                                bus.ps2_mouse[25*i+3 -: 3]};
      sh = bus.sens[2*i +: 2];
      dx = $signed({bus.ps2_mouse[25*i+4],
                    bus.ps2_mouse[25*i+8 +: 8]}) >>> sh;
      dy = $signed({bus.ps2_mouse[25*i+5],
                    bus.ps2_mouse[25*i+16 +: 8]}) >>> sh;
      sx = {pos_x[i][9], pos_x[i]} + {{2{dx[8]}}, dx};
      sy = {pos_y[i][9], pos_y[i]} - {{2{dy[8]}}, dy};
      ay = bus.abs_y[8*i +: 8];

      nx_x[i] = pos_x[i];
      nx_y[i] = pos_y[i];
      if (bus.src_sel[i]) begin
        nx_x[i] = {2'b00, bus.abs_x[8*i +: 8]};
        nx_y[i] = {2'b00, 8'(ay - (ay >> 4))};
      end else if (fresh) begin
        nx_x[i] = clamp(sx);
        nx_y[i] = clamp(sy);
      end

      ex  = {2'b00, bus.cycle} - {pos_x[i][9], pos_x[i]};
      ey  = {2'b00, bus.scanline} - {pos_y[i][9], pos_y[i]};
      off = (pos_x[i] >= 10'sd254) || (pos_x[i] <= 10'sd1) ||
            (pos_y[i] >= 10'sd224) || (pos_y[i] <= 10'sd8);
      hit = (mag(ex) <= RADIUS) && (mag(ey) <= RADIUS) && !off;
      dot = ((ey == 11'd0) && (mag(ex) <= 11'd1)) ||
            ((ex == 11'd0) && (mag(ey) <= 11'd1));
      nx_ret[2*i +: 2] = {off, dot};

      nx_light[i] = light_cnt[i];
      if ((bus.scanline != scan_q) && (light_cnt[i] != 9'd0))
        nx_light[i] = light_cnt[i] - 9'd1;
      // A hit overrides the scanline decay in the same cycle
      if (hit) begin
        case (lclass(bus.color))
          2'd3: nx_light[i] = CNT_HI;
          2'd2: nx_light[i] = (light_cnt[i] > CNT_MID) ?
                              light_cnt[i] : CNT_MID;
          2'd1: nx_light[i] = (light_cnt[i] > CNT_LO) ?
                              light_cnt[i] : CNT_LO;
          default: ;
        endcase
      end

      ev  = bus.trig_sel[i] ? bus.ext_btn[i] : (fresh && btn);
      rel = bus.trig_sel[i] ? !bus.ext_btn[i] : (fresh && !btn);
      nx_trig[i] = (trig_cnt[i] != 32'd0) ?
                   trig_cnt[i] - 32'd1 : 32'd0;
      // Presses during pulse or lockout are dropped, not queued
      if (ev && !pressed[i]) begin
        nx_pressed[i] = 1'b1;
        if (trig_cnt[i] == 32'd0) nx_trig[i] = TRIG_LOAD;
      end else if (rel) begin
        nx_pressed[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_GUNS; i++) begin
        pos_x[i]     <= 10'sd128;
        pos_y[i]     <= 10'sd120;
        light_cnt[i] <= '0;
        trig_cnt[i]  <= '0;
      end
      pressed    <= '0;
      old_toggle <= '0;
      scan_q     <= '0;
      reticle_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_GUNS; i++) begin
        pos_x[i]      <= nx_x[i];
        pos_y[i]      <= nx_y[i];
        light_cnt[i]  <= nx_light[i];
        trig_cnt[i]   <= nx_trig[i];
        old_toggle[i] <= bus.ps2_mouse[25*i+24];
      end
      pressed   <= nx_pressed;
      scan_q    <= bus.scanline;
      reticle_q <= nx_ret;
    end
  end

  always_comb begin
    bus.light   = '1;
    bus.trigger = '0;
    bus.reticle = reticle_q;
    for (int i = 0; i < NUM_GUNS; i++) begin
      bus.light[i]   = light_cnt[i] == 9'd0;
      bus.trigger[i] = trig_cnt[i] > TRIG_HOLD;
    end
  end
endmodule
